// File: rtl/adv_i2c_config.sv
// ADV7511 configuration sequencer: writes a fixed 14-entry register table over an
// open-drain I2C master and replays it after every hot-plug rising edge.
module adv_i2c_config #(
  parameter int         CLK_HZ         = 50_000_000,
  parameter int         I2C_HZ         = 100_000,
  parameter logic [6:0] DEV_ADDR       = 7'h39,
  parameter int         STARTUP_CYCLES = 10_000_000,
  parameter int         MAX_RETRY      = 3
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       restart,
  input  logic       hpd,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] entry_idx
);
  localparam int DIV_RAW = CLK_HZ / (4 * I2C_HZ);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = $clog2(DIV + 1);
  localparam int SW      = $clog2(STARTUP_CYCLES + 1);
  localparam int RW      = $clog2(MAX_RETRY + 1) + 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
  localparam logic [SW-1:0] WAIT_LAST  = SW'(STARTUP_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
  localparam logic [3:0]    LAST_ENTRY = 4'd13;

  // NEXT is folded into the last STOP quarter so done lands one cycle after it.
  typedef enum logic [2:0] {
    S_WAIT, S_START, S_SHIFT, S_ACK, S_STOP, S_DONE, S_ERROR
  } state_t;

  state_t        state_q;
  logic [1:0]    ph_q;
  logic [2:0]    bit_q;
  logic [1:0]    byte_q;
  logic [3:0]    entry_q;
  logic [RW-1:0] retry_q;
  logic [SW-1:0] cnt_q;
  logic [DW-1:0] div_q;
  logic          nack_q, abort_q;
  logic          scl_q, sda_q, busy_q, done_q, error_q;
  logic [2:0]    hpd_q;
  logic [1:0]    sda_s_q;
  logic          tick, hpd_rise;
  logic [15:0]   cur_entry;
  logic [7:0]    cur_byte;

  function automatic logic [15:0] table_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    table_entry = 16'h4110;
      4'd1:    table_entry = 16'h9803;
      4'd2:    table_entry = 16'h9AE0;
      4'd3:    table_entry = 16'h9C30;
      4'd4:    table_entry = 16'h9D61;
      4'd5:    table_entry = 16'hA2A4;
      4'd6:    table_entry = 16'hA3A4;
      4'd7:    table_entry = 16'hE0D0;
      4'd8:    table_entry = 16'hF900;
      4'd9:    table_entry = 16'h1505;
      4'd10:   table_entry = 16'h1630;
      4'd11:   table_entry = 16'h1702;
      4'd12:   table_entry = 16'h1846;
      default: table_entry = 16'hAF06;
    endcase
  endfunction

  always_comb begin
    cur_entry = table_entry(entry_q);
    case (byte_q)
      2'd0:    cur_byte = {DEV_ADDR, 1'b0};
      2'd1:    cur_byte = cur_entry[15:8];
      default: cur_byte = cur_entry[7:0];
    endcase
  end

  assign tick     = (div_q == DIV_LAST);
  assign hpd_rise = hpd_q[1] & ~hpd_q[2];

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      hpd_q   <= '0;
      sda_s_q <= '0;
    end else begin
      div_q   <= tick ? '0 : div_q + DW'(1);
      hpd_q   <= {hpd_q[1:0], hpd};
      sda_s_q <= {sda_s_q[0], sda_i};
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT;
      ph_q    <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      entry_q <= '0;
      retry_q <= '0;
      cnt_q   <= '0;
      nack_q  <= 1'b0;
      abort_q <= 1'b0;
      scl_q   <= 1'b0;
      sda_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else if (hpd_rise) begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (state_q inside {S_START, S_SHIFT, S_ACK, S_STOP}) begin
        abort_q <= 1'b1;
        if (state_q != S_STOP) begin
          state_q <= S_STOP;
          ph_q    <= '0;
        end
      end else begin
        state_q <= S_WAIT;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
        scl_q   <= 1'b0;
        sda_q   <= 1'b0;
      end
    end else if (restart) begin
      state_q <= S_START;
      ph_q    <= '0;
      entry_q <= '0;
      retry_q <= '0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else if (state_q == S_WAIT) begin
      if (cnt_q == WAIT_LAST) begin
        state_q <= S_START;
        ph_q    <= '0;
        entry_q <= '0;
        retry_q <= '0;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + SW'(1);
      end
    end else if (tick && state_q != S_DONE && state_q != S_ERROR) begin
      // Every transition happens on quarter 3, so ph_q wraps to 0 naturally.
      ph_q <= ph_q + 2'd1;
      case (state_q)
        S_START: begin
          case (ph_q)
            2'd0: begin
              scl_q  <= 1'b0;
              sda_q  <= 1'b0;
              busy_q <= 1'b1;
              byte_q <= '0;
              bit_q  <= '0;
              nack_q <= 1'b0;
            end
            2'd1:    sda_q   <= 1'b1;
            2'd2:    scl_q   <= 1'b1;
            default: state_q <= S_SHIFT;
          endcase
        end
        S_SHIFT: begin
          case (ph_q)
            2'd0: sda_q <= ~cur_byte[~bit_q];
            2'd1: scl_q <= 1'b0;
            2'd2: ;
            default: begin
              scl_q <= 1'b1;
              bit_q <= bit_q + 3'd1;
              if (bit_q == 3'd7) state_q <= S_ACK;
            end
          endcase
        end
        S_ACK: begin
          case (ph_q)
            2'd0: sda_q  <= 1'b0;
            2'd1: scl_q  <= 1'b0;
            2'd2: nack_q <= sda_s_q[1];
            default: begin
              scl_q <= 1'b1;
              if (nack_q || byte_q == 2'd2) begin
                state_q <= S_STOP;
              end else begin
                state_q <= S_SHIFT;
                byte_q  <= byte_q + 2'd1;
              end
            end
          endcase
        end
        S_STOP: begin
          case (ph_q)
            2'd0: begin
              scl_q <= 1'b1;
              sda_q <= 1'b1;
            end
            2'd1: scl_q <= 1'b0;
            2'd2: sda_q <= 1'b0;
            default: begin
              if (abort_q) begin
                state_q <= S_WAIT;
                cnt_q   <= '0;
                busy_q  <= 1'b0;
                abort_q <= 1'b0;
              end else if (nack_q) begin
                if (retry_q == RETRY_MAX) begin
                  state_q <= S_ERROR;
                  error_q <= 1'b1;
                  busy_q  <= 1'b0;
                end else begin
                  state_q <= S_START;
                  retry_q <= retry_q + RW'(1);
                end
              end else if (entry_q == LAST_ENTRY) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                state_q <= S_START;
                entry_q <= entry_q + 4'd1;
                retry_q <= '0;
              end
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign scl_oe    = scl_q;
  assign sda_oe    = sda_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign entry_idx = entry_q;
endmodule

// File: tb/tb_adv_i2c_config.sv
// Bench for adv_i2c_config: an I2C slave/monitor decodes every framed write and the
// observed frames are compared with a table-level model of the expected traffic.
module tb_adv_i2c_config;
  localparam int MAX_RETRY = 3;

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         n;
  } frame_t;

  logic clk = 1'b0, reset = 1'b1, restart = 1'b0, hpd = 1'b0;
  logic scl_oe, sda_oe, busy, done, error;
  logic [3:0] entry_idx;
  logic slave_pull = 1'b0;
  logic sda_i;

  assign sda_i = !sda_oe && !slave_pull;

  adv_i2c_config #(
    .CLK_HZ(800_000), .I2C_HZ(100_000), .DEV_ADDR(7'h39),
    .STARTUP_CYCLES(20), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk_in(clk), .reset(reset), .restart(restart), .hpd(hpd), .sda_i(sda_i),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .busy(busy), .done(done), .error(error),
    .entry_idx(entry_idx)
  );

  always #5 clk = ~clk;

  logic [15:0] tbl [14] = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4,
                            16'hA3A4, 16'hE0D0, 16'hF900, 16'h1505, 16'h1630, 16'h1702,
                            16'h1846, 16'hAF06};

  int tests = 0, fails = 0;
  frame_t exp_q[$], obs_q[$];
  int exp_done, exp_err, exp_idx;
  int pol_entry = -1, pol_byte = 0, pol_n = 0;

  // Monitor/slave state (written only by the monitor process).
  logic mon_clr = 1'b0;
  int cyc = 0, start_cnt = 0, stop_cnt = 0, last_start_cyc = 0, last_stop_cyc = 0;
  int mon_entry = 0, mon_bitcnt = 0, mon_nbytes = 0, nack_used = 0;
  logic mon_in = 1'b0, mon_nack = 1'b0, prev_scl = 1'b1, prev_sda = 1'b1;
  logic m_scl, m_sda, m_nk;
  logic [7:0] mon_sh = 8'h0;
  logic [7:0] mb [3];
  frame_t mf;

  always @(negedge clk) begin
    cyc++;
    if (mon_clr) begin
      obs_q.delete();
      mon_in = 1'b0; mon_bitcnt = 0; mon_nbytes = 0; mon_entry = 0; nack_used = 0;
      slave_pull = 1'b0; prev_scl = 1'b1; prev_sda = 1'b1;
    end else begin
      m_scl = !scl_oe;
      m_sda = !sda_oe && !slave_pull;
      if (prev_scl && m_scl && prev_sda && !m_sda) begin
        mon_in = 1'b1; mon_bitcnt = 0; mon_nbytes = 0; mon_nack = 1'b0;
        start_cnt++; last_start_cyc = cyc;
      end else if (prev_scl && m_scl && !prev_sda && m_sda) begin
        if (mon_in) begin
          mf.n = mon_nbytes; mf.b0 = mb[0]; mf.b1 = mb[1]; mf.b2 = mb[2];
          obs_q.push_back(mf);
          if (!mon_nack && mon_nbytes == 3) mon_entry++;
        end
        mon_in = 1'b0; stop_cnt++; last_stop_cyc = cyc;
      end else if (mon_in && !prev_scl && m_scl) begin
        if (mon_bitcnt < 8) mon_sh = {mon_sh[6:0], m_sda};
        mon_bitcnt++;
      end else if (mon_in && prev_scl && !m_scl) begin
        if (mon_bitcnt == 8) begin
          if (mon_nbytes < 3) mb[mon_nbytes] = mon_sh;
          m_nk = (mon_entry == pol_entry && mon_nbytes == pol_byte && nack_used < pol_n);
          if (m_nk) begin nack_used++; mon_nack = 1'b1; end
          slave_pull = !m_nk;
        end else if (mon_bitcnt == 9) begin
          slave_pull = 1'b0; mon_nbytes++; mon_bitcnt = 0;
        end
      end
      prev_scl = m_scl;
      prev_sda = !sda_oe && !slave_pull;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    tests++;
    assert (obs >= lo && obs <= hi) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic logic [31:0] fkey(input frame_t f);
    return {8'(f.n), f.b0, (f.n >= 2) ? f.b1 : 8'h0, (f.n >= 3) ? f.b2 : 8'h0};
  endfunction

  // Expected traffic from the table: te = entry that sees nn NACKs on byte tb.
  task automatic build_model(input int te, input int tb, input int nn);
    frame_t f;
    exp_q.delete(); exp_done = 0; exp_err = 0; exp_idx = 0;
    for (int e = 0; e < 14; e++) begin
      f.b0 = 8'h72; f.b1 = tbl[e][15:8]; f.b2 = tbl[e][7:0];
      exp_idx = e;
      if (e == te) begin
        for (int a = 0; a < nn && a <= MAX_RETRY; a++) begin
          f.n = tb + 1; exp_q.push_back(f);
        end
        if (nn > MAX_RETRY) begin exp_err = 1; return; end
      end
      f.n = 3; exp_q.push_back(f);
    end
    exp_done = 1;
  endtask

  task automatic mon_clear();
    @(posedge clk); mon_clr = 1'b1;
    @(posedge clk); mon_clr = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(done || error) && n < 20000) begin @(negedge clk); n++; end
    chk({tag, ":finished"}, done || error, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_start(input string tag, input int s0);
    int n = 0;
    while (start_cnt == s0 && n < 200) begin @(negedge clk); n++; end
    chk({tag, ":start_seen"}, start_cnt != s0, 1);
  endtask

  task automatic check_run(input string tag);
    chk({tag, ":frames"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s:frame%0d", tag, i), fkey(obs_q[i]), fkey(exp_q[i]));
    chk({tag, ":done"}, done, exp_done);
    chk({tag, ":error"}, error, exp_err);
    chk({tag, ":entry_idx"}, entry_idx, exp_idx);
    chk({tag, ":busy"}, busy, 0);
    chk({tag, ":lines"}, {scl_oe, sda_oe}, 0);
  endtask

  task automatic run_seq(input string tag, input int te, input int tb, input int nn);
    int s0, t0;
    $display("[TB] %s: nack entry=%0d byte=%0d count=%0d", tag, te, tb, nn);
    build_model(te, tb, nn);
    pol_entry = te; pol_byte = tb; pol_n = nn;
    mon_clear();
    s0 = start_cnt;
    @(negedge clk); restart = 1'b1; t0 = cyc;
    @(negedge clk); restart = 1'b0;
    chk({tag, ":cleared"}, {done, error}, 0);
    wait_start(tag, s0);
    chk_range({tag, ":restart_gap"}, last_start_cyc - t0, 1, 8);
    wait_end(tag);
    check_run(tag);
  endtask

  initial begin
    int n, s0, t0;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst:scl_oe", scl_oe, 0);
    chk("rst:sda_oe", sda_oe, 0);
    chk("rst:busy", busy, 0);
    chk("rst:done", done, 0);
    chk("rst:error", error, 0);
    chk("rst:entry_idx", entry_idx, 0);
    mon_clear();

    // Nominal power-up run from reset, including startup wait timing
    build_model(-1, 0, 0);
    @(negedge clk); reset = 1'b0; n = 0;
    while (!done && !error && n < 20000) begin
      @(negedge clk); n++;
      if (n == 500) chk("nominal:busy_mid", busy, 1);
    end
    $display("[TB] nominal: done after %0d cycles", n);
    chk_range("nominal:done_latency", n, 3262, 3274);
    repeat (4) @(negedge clk);
    check_run("nominal");

    run_seq("nack_e3_data", 3, 2, 1);
    run_seq("nack_addr_perm", 0, 0, 100);
    for (int i = 0; i < 3; i++)
      run_seq($sformatf("random%0d", i), $urandom_range(0, 13), $urandom_range(0, 2),
              $urandom_range(0, 5));
    run_seq("nominal_restart", -1, 0, 0);

    // HPD rising edge during entry 7
    build_model(-1, 0, 0); pol_entry = -1; pol_n = 0;
    mon_clear();
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    n = 0;
    while (!(mon_entry == 7 && mon_in && mon_bitcnt >= 2) && n < 10000) begin
      @(negedge clk); n++;
    end
    chk("hpd7:reached_entry7", mon_entry, 7);
    s0 = stop_cnt; hpd = 1'b1; n = 0;
    while (stop_cnt == s0 && n < 200) begin @(negedge clk); n++; end
    chk("hpd7:stop_seen", stop_cnt != s0, 1);
    $display("[TB] hpd7: STOP %0d cycles after HPD rise", n);
    repeat (6) @(negedge clk);
    chk("hpd7:busy_in_wait", busy, 0);
    chk("hpd7:lines_in_wait", {scl_oe, sda_oe}, 0);
    s0 = start_cnt;
    mon_clear();
    wait_start("hpd7", s0);
    chk_range("hpd7:wait_gap", last_start_cyc - last_stop_cyc, 20, 40);
    wait_end("hpd7");
    check_run("hpd7");

    // HPD rising edge while in DONE
    @(negedge clk); hpd = 1'b0;
    repeat (5) @(negedge clk);
    mon_clear();
    s0 = start_cnt;
    @(negedge clk); hpd = 1'b1; t0 = cyc;
    repeat (5) @(negedge clk);
    chk("hpd_done:done_cleared", done, 0);
    wait_start("hpd_done", s0);
    chk_range("hpd_done:wait_gap", last_start_cyc - t0, 20, 40);
    wait_end("hpd_done");
    check_run("hpd_done");

    // Asynchronous reset in the middle of the register byte of entry 2
    mon_clear();
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    n = 0;
    while (!(mon_entry == 2 && mon_in && mon_nbytes == 1 && scl_oe && sda_oe) && n < 10000) begin
      @(negedge clk); n++;
    end
    chk("rst_mid:reached_shift", {scl_oe, sda_oe}, 2'b11);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid:lines_released", {scl_oe, sda_oe}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0; t0 = cyc;
    s0 = start_cnt;
    mon_clear();
    wait_start("rst_mid", s0);
    chk_range("rst_mid:wait_gap", last_start_cyc - t0, 20, 40);
    wait_end("rst_mid");
    check_run("rst_mid");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
